// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BRANCH,
        S_JAL,
        S_TRAP,
        S_LUI,
        S_AUIPC
    } state_t;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_R      = 7'b0110011,
        OP_I_ALU  = 7'b0010011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/mc_control_unit_alu_decoder.sv
// ALU decoder: maps alu_op plus funct3/funct7[5]/opcode[5] to an ALU operation.
// Latency: combinational.
// Backpressure: none; flags unsupported funct3 so the FSM can trap.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op_5,
    output logic [2:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (alu_op)
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    // opcode[5] separates R-type from I-type, so addi never becomes sub
                    3'b000:  alu_control = (funct7_5 && op_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b100:  alu_control = ALU_XOR;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: illegal     = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RISC-V control FSM (Moore outputs), optional LUI/AUIPC via MC_CTRL_UPPER_IMM_EN.
// Latency: 3 (branch), 4 (R/I/store/JAL), 5 (load) cycles plus one per memory wait cycle.
// Backpressure: stalls on mem_ready_i in FETCH/MEM_READ/MEM_WRITE; traps after MEM_TIMEOUT waits.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int INSTR_WIDTH    = 32,
    parameter int ALU_CTRL_WIDTH = 3,
    parameter int MEM_TIMEOUT    = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [INSTR_WIDTH-1:0]    instr_i,
    input  logic                      zero_i,
    input  logic                      mem_ready_i,
    output logic                      pc_write_o,
    output logic                      adr_src_o,
    output logic                      mem_write_o,
    output logic                      ir_write_o,
    output logic [1:0]                result_src_o,
    output logic [1:0]                alu_src_a_o,
    output logic [1:0]                alu_src_b_o,
    output logic [ALU_CTRL_WIDTH-1:0] alu_control_o,
    output logic [2:0]                imm_src_o,
    output logic                      reg_write_o,
    output logic                      trap_o,
    output logic [1:0]                trap_cause_o
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       trap_cause_next;
    logic             in_wait;
    logic             timeout_hit;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    alu_op_t          alu_op;
    logic [2:0]       alu_ctrl;
    logic             funct_illegal;

    logic             pc_write;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7_5    (instr_i[30]),
        .op_5        (opcode[5]),
        .alu_control (alu_ctrl),
        .illegal     (funct_illegal)
    );

    assign in_wait     = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
    // The access that would be the MEM_TIMEOUT-th consecutive not-ready cycle traps.
    assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready_i && (wait_cnt >= LIMIT);

    always_comb begin
        state_next      = state;
        trap_cause_next = TRAP_NONE;
        pc_write        = 1'b0;
        adr_src_o       = 1'b0;
        mem_write       = 1'b0;
        ir_write        = 1'b0;
        reg_write       = 1'b0;
        result_src_o    = RES_ALUOUT;
        alu_src_a_o     = SRC_A_PC;
        alu_src_b_o     = SRC_B_RS2;
        alu_op          = ALU_OP_ADD;
        case (state)
            S_FETCH: begin
                alu_src_b_o  = SRC_B_FOUR;
                result_src_o = RES_ALU;
                if (mem_ready_i) begin
                    pc_write   = 1'b1;
                    ir_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    state_next      = S_TRAP;
                    trap_cause_next = TRAP_TIMEOUT;
                end
            end
            S_DECODE: begin
                alu_src_a_o = SRC_A_OLDPC;
                alu_src_b_o = SRC_B_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
                    OP_R:              state_next = S_EXEC_R;
                    OP_I_ALU:          state_next = S_EXEC_I;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
`ifdef MC_CTRL_UPPER_IMM_EN
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
`endif
                    default: begin
                        state_next      = S_TRAP;
                        trap_cause_next = TRAP_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
                state_next  = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                adr_src_o = 1'b1;
                if (mem_ready_i) begin
                    state_next = S_MEM_WB;
                end else if (timeout_hit) begin
                    state_next      = S_TRAP;
                    trap_cause_next = TRAP_TIMEOUT;
                end
            end
            S_MEM_WRITE: begin
                adr_src_o = 1'b1;
                mem_write = 1'b1;
                if (mem_ready_i) begin
                    state_next = S_FETCH;
                end else if (timeout_hit) begin
                    state_next      = S_TRAP;
                    trap_cause_next = TRAP_TIMEOUT;
                end
            end
            S_MEM_WB: begin
                result_src_o = RES_RDATA;
                reg_write    = 1'b1;
                state_next   = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = (state == S_EXEC_I) ? SRC_B_IMM : SRC_B_RS2;
                alu_op      = ALU_OP_FUNCT;
                if (funct_illegal) begin
                    state_next      = S_TRAP;
                    trap_cause_next = TRAP_ILLEGAL;
                end else begin
                    state_next = S_ALU_WB;
                end
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_RS2;
                alu_op      = ALU_OP_SUB;
                state_next  = S_FETCH;
                case (funct3)
                    3'b000:  pc_write = zero_i;
                    3'b001:  pc_write = !zero_i;
                    default: begin
                        state_next      = S_TRAP;
                        trap_cause_next = TRAP_ILLEGAL;
                    end
                endcase
            end
            S_JAL: begin
                alu_src_a_o = SRC_A_OLDPC;
                alu_src_b_o = SRC_B_FOUR;
                pc_write    = 1'b1;
                state_next  = S_ALU_WB;
            end
`ifdef MC_CTRL_UPPER_IMM_EN
            S_LUI: begin
                alu_src_a_o = SRC_A_ZERO;
                alu_src_b_o = SRC_B_IMM;
                state_next  = S_ALU_WB;
            end
            S_AUIPC: begin
                alu_src_a_o = SRC_A_OLDPC;
                alu_src_b_o = SRC_B_IMM;
                state_next  = S_ALU_WB;
            end
`endif
            S_TRAP: state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_LOAD, OP_I_ALU: imm_src_o = IMM_I;
            OP_STORE:          imm_src_o = IMM_S;
            OP_BRANCH:         imm_src_o = IMM_B;
            OP_JAL:            imm_src_o = IMM_J;
`ifdef MC_CTRL_UPPER_IMM_EN
            OP_LUI, OP_AUIPC:  imm_src_o = IMM_U;
`endif
            default:           imm_src_o = IMM_I;
        endcase
    end

    // Write enables are forced low while reset is held so an aborted access never writes.
    assign pc_write_o    = pc_write  && rst_ni;
    assign ir_write_o    = ir_write  && rst_ni;
    assign mem_write_o   = mem_write && rst_ni;
    assign reg_write_o   = reg_write && rst_ni;
    assign alu_control_o = ALU_CTRL_WIDTH'(alu_ctrl);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_FETCH;
            wait_cnt     <= '0;
            trap_o       <= 1'b0;
            trap_cause_o <= TRAP_NONE;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (in_wait && !mem_ready_i && (wait_cnt != {CNT_W{1'b1}})) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if ((state_next == S_TRAP) && (state != S_TRAP)) begin
                trap_o       <= 1'b1;
                trap_cause_o <= trap_cause_next;
            end
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: checks per-cycle control outputs against hand-computed vectors.
module tb_mc_control_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, adr_src, mem_write, ir_write, reg_write, trap;
    logic [1:0]  result_src, alu_src_a, alu_src_b, trap_cause;
    logic [2:0]  alu_control, imm_src;

    int n_tests = 0;
    int n_fail  = 0;

    mc_control_unit #(
        .INSTR_WIDTH    (32),
        .ALU_CTRL_WIDTH (3),
        .MEM_TIMEOUT    (16)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .instr_i       (instr),
        .zero_i        (zero),
        .mem_ready_i   (mem_ready),
        .pc_write_o    (pc_write),
        .adr_src_o     (adr_src),
        .mem_write_o   (mem_write),
        .ir_write_o    (ir_write),
        .result_src_o  (result_src),
        .alu_src_a_o   (alu_src_a),
        .alu_src_b_o   (alu_src_b),
        .alu_control_o (alu_control),
        .imm_src_o     (imm_src),
        .reg_write_o   (reg_write),
        .trap_o        (trap),
        .trap_cause_o  (trap_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] obs_sig;
    assign obs_sig = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                      alu_src_b, alu_control, imm_src, reg_write};

    function automatic logic [16:0] sig(input logic pcw, input logic adr, input logic mw,
                                        input logic irw, input logic [1:0] res,
                                        input logic [1:0] a, input logic [1:0] b,
                                        input logic [2:0] alu, input logic [2:0] imm,
                                        input logic rw);
        return {pcw, adr, mw, irw, res, a, b, alu, imm, rw};
    endfunction

    function automatic logic [16:0] f_fetch(input logic rdy, input logic [2:0] imm);
        return sig(rdy, 1'b0, 1'b0, rdy, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0);
    endfunction

    function automatic logic [16:0] f_dec(input logic [2:0] imm);
        return sig(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0);
    endfunction

    function automatic logic [16:0] f_wb(input logic [2:0] imm);
        return sig(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b1);
    endfunction

    task automatic chk(input string tag, input logic [16:0] exp_sig, input logic exp_trap,
                       input logic [1:0] exp_cause);
        n_tests++;
        assert ({obs_sig, trap, trap_cause} === {exp_sig, exp_trap, exp_cause})
        else begin
            n_fail++;
            $error("FAIL %s: observed sig=%b trap=%b cause=%b, expected sig=%b trap=%b cause=%b",
                   tag, obs_sig, trap, trap_cause, exp_sig, exp_trap, exp_cause);
        end
    endtask

    task automatic cyc(input logic rdy, input logic z);
        @(negedge clk);
        mem_ready = rdy;
        zero      = z;
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        zero      = 1'b0;
        #3;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b0;
        instr     = 32'h002081B3;
        #1;
        chk("reset", f_fetch(1'b0, 3'b000), 1'b0, 2'b00);
        do_reset();

        // add x3,x1,x2
        instr = 32'h002081B3;
        cyc(1, 0); chk("add_fetch", f_fetch(1'b1, 3'b000), 1'b0, 2'b00);
        cyc(1, 0); chk("add_decode", f_dec(3'b000), 1'b0, 2'b00);
        cyc(1, 0); chk("add_exec", sig(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0), 1'b0, 2'b00);
        cyc(1, 0); chk("add_wb", f_wb(3'b000), 1'b0, 2'b00);

        // sub x3,x1,x2
        instr = 32'h402081B3;
        cyc(1, 0); chk("sub_fetch", f_fetch(1'b1, 3'b000), 1'b0, 2'b00);
        cyc(1, 0); chk("sub_decode", f_dec(3'b000), 1'b0, 2'b00);
        cyc(1, 0); chk("sub_exec", sig(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0), 1'b0, 2'b00);
        cyc(1, 0); chk("sub_wb", f_wb(3'b000), 1'b0, 2'b00);

        // addi x1,x0,5
        instr = 32'h00500093;
        cyc(1, 0); chk("addi_fetch", f_fetch(1'b1, 3'b000), 1'b0, 2'b00);
        cyc(1, 0); chk("addi_decode", f_dec(3'b000), 1'b0, 2'b00);
        cyc(1, 0); chk("addi_exec", sig(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0), 1'b0, 2'b00);
        cyc(1, 0); chk("addi_wb", f_wb(3'b000), 1'b0, 2'b00);

        // lw x5,4(x1) with three wait cycles in MEM_READ: 8 cycles total
        instr = 32'h0040A283;
        cyc(1, 0); chk("lw_fetch", f_fetch(1'b1, 3'b000), 1'b0, 2'b00);
        cyc(1, 0); chk("lw_decode", f_dec(3'b000), 1'b0, 2'b00);
        cyc(1, 0); chk("lw_madr", sig(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0), 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0); chk("lw_read_wait", sig(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0), 1'b0, 2'b00);
        end
        cyc(1, 0); chk("lw_read_done", sig(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0), 1'b0, 2'b00);
        cyc(1, 0); chk("lw_wb", sig(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1), 1'b0, 2'b00);

        // sw x2,8(x1)
        instr = 32'h0020A423;
        cyc(1, 0); chk("lw_then_fetch", f_fetch(1'b1, 3'b001), 1'b0, 2'b00);
        cyc(1, 0); chk("sw_decode", f_dec(3'b001), 1'b0, 2'b00);
        cyc(1, 0); chk("sw_madr", sig(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0), 1'b0, 2'b00);
        cyc(1, 0); chk("sw_write", sig(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0), 1'b0, 2'b00);

        // bne with zero=0 takes the branch
        instr = 32'h00209463;
        cyc(1, 0); chk("bne_fetch", f_fetch(1'b1, 3'b010), 1'b0, 2'b00);
        cyc(1, 0); chk("bne_decode", f_dec(3'b010), 1'b0, 2'b00);
        cyc(1, 0); chk("bne_branch", sig(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0), 1'b0, 2'b00);

        // beq with zero=0 does not branch
        instr = 32'h00208463;
        cyc(1, 0); chk("beq_fetch", f_fetch(1'b1, 3'b010), 1'b0, 2'b00);
        cyc(1, 0); chk("beq_decode", f_dec(3'b010), 1'b0, 2'b00);
        cyc(1, 0); chk("beq_nz_branch", sig(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0), 1'b0, 2'b00);
        cyc(1, 0); chk("beq_return", f_fetch(1'b1, 3'b010), 1'b0, 2'b00);
        cyc(1, 0); chk("beq2_decode", f_dec(3'b010), 1'b0, 2'b00);
        cyc(1, 1); chk("beq_z_branch", sig(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0), 1'b0, 2'b00);

        // jal x1,16
        instr = 32'h010000EF;
        cyc(1, 0); chk("jal_fetch", f_fetch(1'b1, 3'b011), 1'b0, 2'b00);
        cyc(1, 0); chk("jal_decode", f_dec(3'b011), 1'b0, 2'b00);
        cyc(1, 0); chk("jal_jal", sig(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011, 0), 1'b0, 2'b00);
        cyc(1, 0); chk("jal_wb", f_wb(3'b011), 1'b0, 2'b00);

        // store aborted by async reset while waiting in MEM_WRITE
        instr = 32'h0020A423;
        cyc(1, 0); chk("swr_fetch", f_fetch(1'b1, 3'b001), 1'b0, 2'b00);
        cyc(1, 0); chk("swr_decode", f_dec(3'b001), 1'b0, 2'b00);
        cyc(1, 0); chk("swr_madr", sig(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0), 1'b0, 2'b00);
        cyc(0, 0); chk("swr_write", sig(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0), 1'b0, 2'b00);
        rst_n = 1'b0;
        #1;
        chk("swr_reset", f_fetch(1'b0, 3'b001), 1'b0, 2'b00);
        do_reset();
        cyc(0, 0); chk("swr_after", f_fetch(1'b0, 3'b001), 1'b0, 2'b00);
        do_reset();

        // illegal opcode 0x7F
        instr = 32'h0000007F;
        cyc(1, 0); chk("ill_fetch", f_fetch(1'b1, 3'b000), 1'b0, 2'b00);
        cyc(1, 0); chk("ill_decode", f_dec(3'b000), 1'b0, 2'b00);
        cyc(1, 0); chk("ill_trap", 17'b0, 1'b1, 2'b01);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1); chk("ill_hold", 17'b0, 1'b1, 2'b01);
        end
        do_reset();

        // slli: funct3 001 unsupported
        instr = 32'h00109093;
        cyc(1, 0); chk("slli_fetch", f_fetch(1'b1, 3'b000), 1'b0, 2'b00);
        cyc(1, 0); chk("slli_decode", f_dec(3'b000), 1'b0, 2'b00);
        cyc(1, 0); chk("slli_exec", sig(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0), 1'b0, 2'b00);
        cyc(1, 0); chk("slli_trap", 17'b0, 1'b1, 2'b01);
        do_reset();

        // fetch timeout: 16 not-ready cycles trap
        instr = 32'h002081B3;
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0); chk("to_wait", f_fetch(1'b0, 3'b000), 1'b0, 2'b00);
        end
        cyc(0, 0); chk("to_trap", 17'b0, 1'b1, 2'b10);
        do_reset();

        // ready on the 16th cycle completes without trapping
        for (int i = 0; i < 15; i++) begin
            cyc(0, 0); chk("nto_wait", f_fetch(1'b0, 3'b000), 1'b0, 2'b00);
        end
        cyc(1, 0); chk("nto_ready", f_fetch(1'b1, 3'b000), 1'b0, 2'b00);
        cyc(1, 0); chk("nto_decode", f_dec(3'b000), 1'b0, 2'b00);
        do_reset();

        // lui x5,0x12345
        instr = 32'h123452B7;
`ifdef MC_CTRL_UPPER_IMM_EN
        cyc(1, 0); chk("lui_fetch", f_fetch(1'b1, 3'b100), 1'b0, 2'b00);
        cyc(1, 0); chk("lui_decode", f_dec(3'b100), 1'b0, 2'b00);
        cyc(1, 0); chk("lui_exec", sig(0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b000, 3'b100, 0), 1'b0, 2'b00);
        cyc(1, 0); chk("lui_wb", f_wb(3'b100), 1'b0, 2'b00);
`else
        cyc(1, 0); chk("lui_fetch", f_fetch(1'b1, 3'b000), 1'b0, 2'b00);
        cyc(1, 0); chk("lui_decode", f_dec(3'b000), 1'b0, 2'b00);
        cyc(1, 0); chk("lui_trap", 17'b0, 1'b1, 2'b01);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multicycle RISC-V control unit: a Moore-style state machine that sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port. It sits between the instruction register and the multicycle datapath and replaces the single-cycle decoder. It adds a memory-ready handshake with a bounded timeout, and a sticky trap on illegal opcodes.

## Interface
- `INSTR_WIDTH`, 32: instruction width; must be 32.
- `ALU_CTRL_WIDTH`, 3: ALU control width; must be ≥3.
- `MEM_TIMEOUT`, 16: maximum wait cycles on `mem_ready_i`; 0 disables the timeout.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `instr_i` in INSTR_WIDTH: instruction register contents.
- `zero_i` in 1: ALU zero flag.
- `mem_ready_i` in 1: memory access completes this cycle.
- `pc_write_o` out 1: PC register enable.
- `adr_src_o` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_write_o` out 1: memory write enable.
- `ir_write_o` out 1: instruction register and OldPC enable.
- `result_src_o` out 2: result select; 00 = ALUOut, 01 = read data, 10 = ALU result.
- `alu_src_a_o` out 2: ALU A select; 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- `alu_src_b_o` out 2: ALU B select; 00 = rs2, 01 = immediate, 10 = constant 4.
- `alu_control_o` out ALU_CTRL_WIDTH: ALU operation; 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- `imm_src_o` out 3: immediate format; 000 I, 001 S, 010 B, 011 J, 100 U.
- `reg_write_o` out 1: register file write enable.
- `trap_o` out 1: sticky fault flag.
- `trap_cause_o` out 2: fault cause; 01 = illegal opcode, 10 = memory timeout.

## Operation
States: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, TRAP. LUI and AUIPC are added under the configuration macro.

- **FETCH**: adr_src 0, A = PC, B = 4, add, result 10.
  - ir_write and pc_write are asserted only when `mem_ready_i` is 1; that same cycle moves to DECODE.
  - Otherwise the machine stays in FETCH.
- **DECODE**: A = OldPC, B = imm, add (branch/JAL target into ALUOut).
  - Next state by opcode: load/store → MEM_ADR, R-type → EXEC_R, I-ALU → EXEC_I, branch → BRANCH, JAL → JAL.
  - Any other opcode → TRAP with cause 01.
- **MEM_ADR**: A = rs1, B = imm, add. Next is MEM_READ for loads, MEM_WRITE for stores.
- **MEM_READ**: adr_src 1. Moves to MEM_WB when `mem_ready_i` is 1, otherwise waits.
- **MEM_WRITE**: adr_src 1, mem_write 1, held until `mem_ready_i`, then → FETCH.
- **MEM_WB**: result 01, reg_write 1, then → FETCH.
- **EXEC_R / EXEC_I**: A = rs1, B = rs2 or imm. ALU op comes from funct3/funct7.
  - SUB only when funct3 = 000 and `instr_i[30]` = 1 and the opcode is R-type.
  - Unsupported funct3 → TRAP with cause 01.
  - Next state is ALU_WB.
- **ALU_WB**: result 00, reg_write 1, then → FETCH.
- **BRANCH**: A = rs1, B = rs2, sub, result 00.
  - pc_write = `zero_i` for funct3 000 (BEQ), !`zero_i` for funct3 001 (BNE).
  - Other funct3 → TRAP.
  - Next state is FETCH.
- **JAL**: A = OldPC, B = 4, add, result 00, pc_write 1, then → ALU_WB.
- **TRAP**: all enables are 0 and the state is terminal until reset. `trap_o` is 1.
- **imm_src_o** is decoded from the opcode in every state. It is 000 for unknown opcodes.

## Timing
- Reset (asynchronous): state = FETCH, wait counter = 0, `trap_o` = 0, `trap_cause_o` = 00.
  - While `rst_ni` is low, pc_write, ir_write, mem_write and reg_write are 0. All other outputs take their FETCH values.
- Outputs are combinational from state and `instr_i`. The only exceptions are pc_write/ir_write in FETCH (qualified by `mem_ready_i`) and pc_write in BRANCH (qualified by `zero_i`).
- Latency with zero-wait memory:
  - R-type, I-type, store, JAL: 4 cycles.
  - Load: 5 cycles.
  - Branch: 3 cycles.
  - Each wait cycle adds 1.
- Wait counter:
  - Increments in each cycle of FETCH, MEM_READ or MEM_WRITE in which `mem_ready_i` is 0.
  - Clears on state exit.
  - When it reaches `MEM_TIMEOUT`, the next state is TRAP with cause 10. With `MEM_TIMEOUT` = 16, a 16th consecutive not-ready cycle traps.
- The counter saturates and never wraps.
- If `mem_ready_i` = 1 in the same cycle the counter reaches its limit, the access completes and there is no trap.
- Reset during any state aborts immediately. Writes of the aborted instruction are never asserted after `rst_ni` falls.

## Configuration
- `MC_CTRL_UPPER_IMM_EN` defined:
  - DECODE sends opcode 0110111 to LUI (A = zero, B = imm) and 0010111 to AUIPC (A = OldPC, B = imm).
  - Both use imm_src 100 and add, then → ALU_WB.
- Undefined: both opcodes trap with cause 01.

## Structure
- Package `mc_ctrl_pkg`: state enum, opcode enum, ALU control constants, imm_src constants, trap cause constants.
- Sub-module `alu_decoder`: maps alu_op (add / sub / funct) plus funct3, funct7[5] and opcode[5] to `alu_control_o`.
  - It also flags an unsupported funct3.

## Test plan
- R-type `add x3,x1,x2` (0x002081B3), `mem_ready_i` held 1:
  - FETCH → DECODE → EXEC_R → ALU_WB → FETCH in 4 cycles.
  - reg_write is 1 only in the ALU_WB cycle, and alu_control is 000 in EXEC_R.
- Load `lw` with `mem_ready_i` low for 3 cycles in MEM_READ: load completes in 8 cycles and reg_write pulses exactly once, in MEM_WB.
- BNE with `zero_i` = 0 asserts pc_write in BRANCH. BEQ with `zero_i` = 0 keeps pc_write at 0. Both return to FETCH.
- Opcode 0x7F: DECODE → TRAP, `trap_cause_o` = 01, and all enables stay 0 for 20 further cycles.
- `mem_ready_i` held 0 in FETCH with `MEM_TIMEOUT` = 16: TRAP with cause 10 on cycle 16. Repeating the run with ready on cycle 16 produces no trap.
- Async reset asserted mid-MEM_WRITE: mem_write drops the same cycle, state = FETCH, and `trap_o` = 0. Also run LUI with and without `MC_CTRL_UPPER_IMM_EN`.
